// File: rtl/alarm_sequencer.sv
// Multi-channel alarm sequencer: per-channel match/trigger detection with pending queue,
// ring/snooze FSM with BCD wake-time arithmetic, ring timeout and missed pulse.
module alarm_sequencer #(
  parameter int unsigned N_ALARM    = 4,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3,
  localparam int unsigned IdW       = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic                   clk_sec,
  input  logic                   rst,
  input  logic [15:0]            now_time,
  input  logic [16*N_ALARM-1:0]  alm_time,
  input  logic [N_ALARM-1:0]     alm_en,
  input  logic                   stop_btn,
  input  logic                   snooze_btn,
  output logic                   aud_en,
  output logic [1:0]             alm_state,
  output logic [IdW-1:0]         alm_id,
  output logic [3:0]             snooze_left,
  output logic                   missed
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRing   = 2'd1,
    StSnooze = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       id_q, id_d;
  logic [3:0]           snl_q, snl_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [15:0]          wake_q, wake_d;
  logic [N_ALARM-1:0]   pend_q, pend_d;
  logic [N_ALARM-1:0]   match_q;
  logic                 aud_q;
  logic                 missed_q, missed_d;

  logic [N_ALARM-1:0]   match, trig, served_oh, served_mask, low_oh;
  logic [IdW-1:0]       low_idx;
  logic                 served_en;
  logic [15:0]          wake_sum;
  logic [6:0]           min_raw, hr_raw, min_w, hr_w;

  always_comb begin
    match     = '0;
    served_oh = '0;
    low_oh    = '0;
    low_idx   = '0;
    for (int i = 0; i < int'(N_ALARM); i++) begin
      match[i]     = alm_en[i] && (alm_time[16*i +: 16] == now_time);
      served_oh[i] = (id_q == IdW'(i));
    end
    // Descending scan so the lowest pending index wins.
    for (int i = int'(N_ALARM) - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = IdW'(i);
    end
    for (int i = 0; i < int'(N_ALARM); i++) begin
      low_oh[i] = (low_idx == IdW'(i));
    end
  end

  assign trig        = match & ~match_q;
  assign served_en   = |(served_oh & alm_en);
  assign served_mask = (state_q != StIdle) ? served_oh : '0;

  // Wake time = now + SNOOZE_MIN, done in binary and converted back to BCD.
  always_comb begin
    min_raw = 7'(now_time[7:4]) * 7'd10 + 7'(now_time[3:0]) + 7'(SNOOZE_MIN);
    hr_raw  = 7'(now_time[15:12]) * 7'd10 + 7'(now_time[11:8]);
    if (min_raw >= 7'd60) begin
      min_w = min_raw - 7'd60;
      hr_w  = hr_raw + 7'd1;
    end else begin
      min_w = min_raw;
      hr_w  = hr_raw;
    end
    if (hr_w >= 7'd24) hr_w = hr_w - 7'd24;
    wake_sum = {4'(hr_w / 7'd10), 4'(hr_w % 7'd10), 4'(min_w / 7'd10), 4'(min_w % 7'd10)};
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    snl_d    = snl_q;
    cnt_d    = cnt_q;
    wake_d   = wake_q;
    missed_d = 1'b0;
    pend_d   = (pend_q | (trig & ~served_mask)) & alm_en;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          state_d = StRing;
          id_d    = low_idx;
          snl_d   = 4'(MAX_SNOOZE);
          cnt_d   = 8'd0;
          pend_d  = pend_d & ~low_oh;
        end
      end
      StRing: begin
        if (!served_en || stop_btn) begin
          state_d = StIdle;
        end else if (snooze_btn) begin
          if (snl_q != 4'd0) begin
            state_d = StSnooze;
            snl_d   = snl_q - 4'd1;
            wake_d  = wake_sum;
          end else begin
            state_d = StIdle;
          end
        end else if (cnt_q == 8'(RING_SEC - 1)) begin
          state_d  = StIdle;
          missed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSnooze: begin
        if (!served_en || stop_btn) begin
          state_d = StIdle;
        end else if (now_time == wake_q) begin
          state_d = StRing;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sec) begin
    // Match history loads during reset so an already-matching alarm does not fire on release.
    match_q <= match;
    if (rst) begin
      state_q  <= StIdle;
      id_q     <= '0;
      snl_q    <= 4'd0;
      cnt_q    <= 8'd0;
      wake_q   <= 16'd0;
      pend_q   <= '0;
      aud_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      snl_q    <= snl_d;
      cnt_q    <= cnt_d;
      wake_q   <= wake_d;
      pend_q   <= pend_d;
      aud_q    <= (state_d == StRing);
      missed_q <= missed_d;
    end
  end

  assign aud_en      = aud_q;
  assign alm_state   = state_q;
  assign alm_id      = id_q;
  assign snooze_left = snl_q;
  assign missed      = missed_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed vector table, hand sequences for snooze/timeout,
// and randomized traffic checked against a minutes-of-day reference model.
module tb_alarm_sequencer;

  localparam int N  = 4;
  localparam int RS = 60;
  localparam int SM = 5;
  localparam int MS = 3;

  logic          clk_sec = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   now_time = 16'h0000;
  logic [16*N-1:0] alm_time;
  logic [N-1:0]  alm_en = '0;
  logic          stop_btn = 1'b0;
  logic          snooze_btn = 1'b0;
  logic          aud_en;
  logic [1:0]    alm_state;
  logic [1:0]    alm_id;
  logic [3:0]    snooze_left;
  logic          missed;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int       m_st = 0, m_id = 0, m_snl = 0, m_age = 0, m_wake = 0;
  bit [N-1:0] m_pend = '0, m_prev = '0;
  bit       m_missed = 0, m_aud = 0;

  alarm_sequencer #(
    .N_ALARM    (N),
    .RING_SEC   (RS),
    .SNOOZE_MIN (SM),
    .MAX_SNOOZE (MS)
  ) dut (
    .clk_sec     (clk_sec),
    .rst         (rst),
    .now_time    (now_time),
    .alm_time    (alm_time),
    .alm_en      (alm_en),
    .stop_btn    (stop_btn),
    .snooze_btn  (snooze_btn),
    .aud_en      (aud_en),
    .alm_state   (alm_state),
    .alm_id      (alm_id),
    .snooze_left (snooze_left),
    .missed      (missed)
  );

  always #5 clk_sec = ~clk_sec;

  function automatic int bcd2min(logic [15:0] t);
    return (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic logic [15:0] min2bcd(int m);
    int h, mm;
    h  = m / 60;
    mm = m % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit [N-1:0] mt, tr, np;
    int j;
    for (int i = 0; i < N; i++) mt[i] = alm_en[i] && (alm_time[16*i +: 16] == now_time);
    if (rst) begin
      m_st = 0; m_id = 0; m_snl = 0; m_age = 0; m_wake = 0;
      m_pend = '0; m_prev = mt; m_missed = 0; m_aud = 0;
      return;
    end
    tr = mt & ~m_prev;
    m_prev = mt;
    for (int i = 0; i < N; i++)
      np[i] = (m_pend[i] || (tr[i] && !(m_st != 0 && i == m_id))) && alm_en[i];
    m_missed = 0;
    case (m_st)
      0: if (m_pend != 0) begin
        j = 0;
        while (!m_pend[j]) j++;
        np[j] = 0; m_st = 1; m_id = j; m_snl = MS; m_age = 0;
      end
      1: begin
        if (!alm_en[m_id] || stop_btn) m_st = 0;
        else if (snooze_btn) begin
          if (m_snl > 0) begin
            m_st = 2; m_snl--; m_wake = (bcd2min(now_time) + SM) % 1440;
          end else m_st = 0;
        end else if (m_age == RS - 1) begin
          m_st = 0; m_missed = 1;
        end else m_age++;
      end
      default: begin
        if (!alm_en[m_id] || stop_btn) m_st = 0;
        else if (bcd2min(now_time) == m_wake) begin
          m_st = 1; m_age = 0;
        end
      end
    endcase
    m_pend = np;
    m_aud  = (m_st == 1);
  endtask

  task automatic tick();
    int exp;
    model_step();
    @(posedge clk_sec);
    #1;
    exp = (int'(m_aud) << 9) | (m_st << 7) | (m_id << 5) | (m_snl << 1) | int'(m_missed);
    check("model {aud,state,id,snl,missed}",
          int'({aud_en, alm_state, alm_id, snooze_left, missed}), exp);
  endtask

  typedef struct {
    bit          rst;
    logic [15:0] now;
    logic [3:0]  en;
    bit          stop;
    bit          snz;
    int          st, aud, id, snl, mis;
  } vec_t;

  function automatic vec_t v(bit r, logic [15:0] n, logic [3:0] e, bit sp, bit sz,
                             int st, int au, int id, int sl, int ms);
    vec_t x;
    x.rst = r; x.now = n; x.en = e; x.stop = sp; x.snz = sz;
    x.st = st; x.aud = au; x.id = id; x.snl = sl; x.mis = ms;
    return x;
  endfunction

  vec_t tbl[$];

  task automatic expect_out(string tag, int st, int au, int id, int sl, int ms);
    check({tag, "_state"}, int'(alm_state), st);
    check({tag, "_aud"}, int'(aud_en), au);
    check({tag, "_id"}, int'(alm_id), id);
    check({tag, "_snl"}, int'(snooze_left), sl);
    check({tag, "_missed"}, int'(missed), ms);
  endtask

  initial begin
    int ring_cycles;
    alm_time = {16'h2358, 16'h0600, 16'h0600, 16'h0730};

    // rst, now, en, stop, snz -> state, aud, id, snl, missed (outputs after the edge)
    tbl.push_back(v(1, 16'h0729, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0729, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0001, 0, 0, 1, 1, 0, 3, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0001, 1, 0, 0, 0, 0, 3, 0));
    tbl.push_back(v(0, 16'h0731, 4'b0111, 0, 0, 0, 0, 0, 3, 0));
    tbl.push_back(v(0, 16'h0600, 4'b0111, 0, 0, 0, 0, 0, 3, 0));
    tbl.push_back(v(0, 16'h0600, 4'b0111, 0, 0, 1, 1, 1, 3, 0));
    tbl.push_back(v(0, 16'h0600, 4'b0111, 1, 0, 0, 0, 1, 3, 0));
    tbl.push_back(v(0, 16'h0600, 4'b0111, 0, 0, 1, 1, 2, 3, 0));
    tbl.push_back(v(0, 16'h0600, 4'b0111, 1, 1, 0, 0, 2, 3, 0));
    tbl.push_back(v(0, 16'h0601, 4'b0111, 0, 0, 0, 0, 2, 3, 0));
    tbl.push_back(v(1, 16'h0730, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0731, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0001, 0, 0, 1, 1, 0, 3, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0001, 0, 0, 1, 1, 0, 3, 0));
    tbl.push_back(v(1, 16'h0730, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0731, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0001, 0, 0, 1, 1, 0, 3, 0));
    tbl.push_back(v(0, 16'h0730, 4'b0000, 0, 0, 0, 0, 0, 3, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; now_time = tbl[i].now; alm_en = tbl[i].en;
      stop_btn = tbl[i].stop; snooze_btn = tbl[i].snz;
      tick();
      expect_out($sformatf("row%0d", i), tbl[i].st, tbl[i].aud, tbl[i].id, tbl[i].snl,
                 tbl[i].mis);
    end
    stop_btn = 0; snooze_btn = 0;

    // Snooze across midnight and snooze exhaustion on channel 3 (23:58).
    rst = 1; tick(); rst = 0;
    alm_en = 4'b1000; now_time = 16'h2357; tick();
    now_time = 16'h2358; tick();
    tick();
    expect_out("snz_ring0", 1, 1, 3, 3, 0);
    snooze_btn = 1; tick(); snooze_btn = 0;
    expect_out("snz_sleep1", 2, 0, 3, 2, 0);
    repeat (3) tick();
    check("snz_hold_state", int'(alm_state), 2);
    now_time = 16'h0002; tick();
    check("snz_early_state", int'(alm_state), 2);
    now_time = 16'h0003; tick();
    expect_out("snz_wake1", 1, 1, 3, 2, 0);
    snooze_btn = 1; tick(); snooze_btn = 0;
    check("snz_sleep2_snl", int'(snooze_left), 1);
    now_time = 16'h0008; tick();
    check("snz_wake2_state", int'(alm_state), 1);
    snooze_btn = 1; tick(); snooze_btn = 0;
    check("snz_sleep3_snl", int'(snooze_left), 0);
    now_time = 16'h0013; tick();
    expect_out("snz_wake3", 1, 1, 3, 0, 0);
    snooze_btn = 1; tick(); snooze_btn = 0;
    expect_out("snz_exhaust", 0, 0, 3, 0, 0);

    // Ring timeout with no button.
    alm_en = 4'b0001; now_time = 16'h0729; tick();
    now_time = 16'h0730; tick();
    tick();
    check("to_enter_state", int'(alm_state), 1);
    ring_cycles = 0;
    for (int k = 0; k < RS - 1; k++) begin
      tick();
      if (alm_state == 2'd1 && aud_en) ring_cycles++;
    end
    check("to_ring_len", ring_cycles, RS - 1);
    tick();
    expect_out("to_missed", 0, 0, 0, 3, 1);
    tick();
    check("to_missed_clear", int'(missed), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        for (int i = 0; i < N; i++) alm_time[16*i +: 16] = min2bcd($urandom_range(0, 1439));
        alm_en = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 9) >= 6) begin
        int k, off, sel;
        k   = $urandom_range(0, N - 1);
        sel = $urandom_range(0, 4);
        off = (sel == 0) ? -1 : (sel - 1) * SM;
        now_time = min2bcd((bcd2min(alm_time[16*k +: 16]) + off + 1440) % 1440);
      end
      if ($urandom_range(0, 39) == 0) alm_en[$urandom_range(0, N - 1)] ^= 1'b1;
      stop_btn   = ($urandom_range(0, 19) == 0);
      snooze_btn = ($urandom_range(0, 9) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 The block SHALL have parameter N_ALARM, default 4, meaning the number of independent alarm channels (1..8).
REQ-002 The block SHALL have parameter RING_SEC, default 60, meaning the maximum ring length in clk_sec cycles (2..255).
REQ-003 The block SHALL have parameter SNOOZE_MIN, default 5, meaning the snooze offset in minutes (1..59).
REQ-004 The block SHALL have parameter MAX_SNOOZE, default 3, meaning the maximum number of snoozes per alarm event (0..15).
REQ-005 The block SHALL have port clk_sec, input, 1 bit: the 1 Hz system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port now_time, input, 16 bits: current time as BCD {hourdec, hourone, mindec, minone}.
REQ-008 The block SHALL have port alm_time, input, 16*N_ALARM bits: alarm i time in bits [16i+15:16i], same BCD layout.
REQ-009 The block SHALL have port alm_en, input, N_ALARM bits: per-channel enable.
REQ-010 The block SHALL have port stop_btn, input, 1 bit: single-cycle stop request.
REQ-011 The block SHALL have port snooze_btn, input, 1 bit: single-cycle snooze request.
REQ-012 The block SHALL have port aud_en, output, 1 bit: buzzer enable.
REQ-013 The block SHALL have port alm_state, output, 2 bits: 0 IDLE, 1 RING, 2 SNOOZE.
REQ-014 The block SHALL have port alm_id, output, $clog2(N_ALARM) bits (minimum 1): the channel being served.
REQ-015 The block SHALL have port snooze_left, output, 4 bits: remaining snoozes for the current event.
REQ-016 The block SHALL have port missed, output, 1 bit: single-cycle pulse on ring timeout.

Function
REQ-017 Channel i SHALL be matched when alm_en[i]=1 and now_time equals its alm_time; a trigger is the rising edge of match, registered per channel.
REQ-018 A trigger on any channel SHALL set pending[i]; pending[i] SHALL clear when the channel is serviced or when alm_en[i]=0.
REQ-019 In IDLE, when pending is non-zero, the block SHALL enter RING on the next edge, with alm_id set to the lowest pending index, snooze_left set to MAX_SNOOZE, and the ring counter set to 0.
REQ-020 In RING, aud_en SHALL be 1 and the ring counter SHALL increment by 1 per cycle.
REQ-021 In RING, stop_btn SHALL return the block to IDLE.
REQ-022 In RING, snooze_btn with snooze_left>0 SHALL enter SNOOZE, latch wake time = now_time + SNOOZE_MIN, and decrement snooze_left.
REQ-023 In RING, snooze_btn with snooze_left=0 SHALL be treated as stop.
REQ-024 In RING, the ring counter reaching RING_SEC-1 with no button SHALL go to IDLE and pulse missed for exactly one cycle.
REQ-025 Wake-time arithmetic SHALL be BCD: minutes carry into hours at 60, and hours wrap from 23 to 00 (23:58 + 5 = 00:03).
REQ-026 In SNOOZE, aud_en SHALL be 0; when now_time equals the wake time, the block SHALL enter RING with the ring counter at 0; stop_btn SHALL go to IDLE.
REQ-027 Simultaneous stop_btn and snooze_btn SHALL be treated as stop.
REQ-028 Clearing alm_en of the served channel in RING or SNOOZE SHALL go to IDLE on the next edge.
REQ-029 Triggers arriving during RING or SNOOZE SHALL only set pending, and SHALL be served in index order after return to IDLE.
REQ-030 A new trigger on the channel being served SHALL be ignored.
REQ-031 Outputs SHALL be registered; the latency from trigger edge to aud_en=1 is 2 cycles (one for the match register, one for the state register).

Reset
REQ-032 While rst=1: alm_state=IDLE, aud_en=0, alm_id=0, snooze_left=0, missed=0, pending=0, and the ring counter=0.
REQ-033 While rst=1, each match register SHALL load the current match vector, so that an alarm already matching at reset release does not fire.
REQ-034 rst asserted mid-RING or mid-SNOOZE SHALL abort the event with no missed pulse.

Verification
REQ-035 Alarm 0 = 07:30, enabled; now_time steps 07:29 -> 07:30 -> aud_en=1 two cycles later, alm_id=0, alm_state=1; stop_btn -> alm_state=0, aud_en=0 next cycle.
REQ-036 Alarm ringing at 23:58 with MAX_SNOOZE=3; snooze_btn -> alm_state=2, snooze_left=2; now_time reaches 00:03 -> alm_state=1, aud_en=1.
REQ-037 Three snoozes exhaust snooze_left to 0; a fourth snooze_btn -> IDLE, aud_en=0.
REQ-038 Ring with no button for RING_SEC=60 cycles -> missed=1 for one cycle, alm_state=0.
REQ-039 Alarms 1 and 2 both set to 06:00 -> alarm 1 rings; stop_btn -> alarm 2 rings next cycle with alm_id=2; stop_btn and snooze_btn asserted together -> IDLE.
REQ-040 rst released while now_time equals alarm 0's time -> no ring; rst pulsed mid-RING -> all outputs at reset values and missed=0.
